fetch_decode: RTL and testbench

Instruction fetch and field-decode stage of the 8-bit ExceptioNull core. It sequences the program counter, issues synchronous reads to instruction memory, and splits each returned 8-bit instruction into opcode, register and 2-bit immediate fields. The immediate field is routed to `sign_extension`; the other fields go to the register file and control. A one-entry skid buffer keeps the stream lossless under downstream stall, and redirect and halt let control steer or stop fetch.

---
 rtl/fetch_decode.sv | 117 +++++++++++
 tb/tb_fetch_decode.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - instruction fetch and field decode stage with one-entry skid buffer
module fetch_decode #(
    parameter int         PC_W    = 8,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd_en,
    input  logic [7:0]      imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            dec_valid,
    output logic [PC_W-1:0] dec_pc,
    output logic [3:0]      dec_opcode,
    output logic [1:0]      dec_rs,
    output logic [1:0]      dec_rt,
    output logic [1:0]      dec_imm,
    output logic            halted
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    logic [PC_W-1:0] pc;
    logic            inflight;
    logic [PC_W-1:0] inflight_pc;
    logic            d_valid;
    logic [7:0]      d_instr;
    logic [PC_W-1:0] d_pc;
    logic            skid_valid;
    logic [7:0]      skid_instr;
    logic [PC_W-1:0] skid_pc;
    logic            halted_q;

    logic consume;
    logic d_free;
    logic resp;
    logic resp_halt;

    // Issue only when the skid is empty, so at most one response can ever be
    // waiting behind a stalled D register; reset forces the strobe low at once.
    assign imem_rd_en = rst_n && !halted_q && !stall && !skid_valid && !redirect;
    assign imem_addr  = pc;

    assign consume   = d_valid && !stall;
    assign d_free    = !d_valid || consume;
    assign resp      = inflight && !halted_q && !redirect;
    assign resp_halt = resp && (imem_rdata[7:4] == HALT_OP);

    assign dec_valid  = d_valid;
    assign dec_pc     = d_pc;
    assign dec_opcode = d_instr[7:4];
    assign dec_rs     = d_instr[3:2];
    assign dec_rt     = d_instr[1:0];
    assign dec_imm    = d_instr[1:0];
    assign halted     = halted_q;

    // Program counter, in-flight tracking, D/skid pipeline and halt flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            d_valid     <= 1'b0;
            d_instr     <= '0;
            d_pc        <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            halted_q    <= 1'b0;
        end else if (redirect) begin
            // Redirect flushes everything and drops the response arriving now.
            pc         <= redirect_pc;
            inflight   <= 1'b0;
            d_valid    <= 1'b0;
            skid_valid <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            inflight    <= imem_rd_en;
            inflight_pc <= pc;
            if (imem_rd_en) begin
                pc <= pc + PC_ONE;
            end

            if (d_free) begin
                if (skid_valid) begin
                    // Older skid entry goes first; a new response backfills skid.
                    d_valid    <= 1'b1;
                    d_instr    <= skid_instr;
                    d_pc       <= skid_pc;
                    skid_valid <= resp;
                    if (resp) begin
                        skid_instr <= imem_rdata;
                        skid_pc    <= inflight_pc;
                    end
                end else if (resp) begin
                    d_valid <= 1'b1;
                    d_instr <= imem_rdata;
                    d_pc    <= inflight_pc;
                end else begin
                    d_valid <= 1'b0;
                end
            end else if (resp) begin
                // D is held by stall; park the response.
                skid_valid <= 1'b1;
                skid_instr <= imem_rdata;
                skid_pc    <= inflight_pc;
            end

            if (resp_halt) begin
                halted_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode.sv
// tb/tb_fetch_decode.sv - scoreboard testbench for fetch_decode
module tb_fetch_decode;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] imem_addr;
    logic       imem_rd_en;
    logic [7:0] imem_rdata;
    logic       stall;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       dec_valid;
    logic [7:0] dec_pc;
    logic [3:0] dec_opcode;
    logic [1:0] dec_rs;
    logic [1:0] dec_rt;
    logic [1:0] dec_imm;
    logic       halted;

    logic [7:0] mem [256];
    logic [7:0] sb [$];
    logic       mon_en;
    int         checks = 0;
    int         errors = 0;

    fetch_decode #(.PC_W(8), .HALT_OP(4'hF)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_opcode(dec_opcode),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_imm(dec_imm), .halted(halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: one-cycle read latency.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    // Scoreboard monitor: every consumed instruction must match the next expected pc.
    always @(negedge clk) begin
        if (mon_en && rst_n && dec_valid && !stall) begin
            logic [7:0] e;
            logic [7:0] ins;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output dec_pc=%02h required=none", dec_pc);
            end else begin
                e   = sb.pop_front();
                ins = mem[e];
                if ({dec_pc, dec_opcode, dec_rs, dec_rt, dec_imm} !==
                    {e, ins[7:4], ins[3:2], ins[1:0], ins[1:0]}) begin
                    errors++;
                    $display("FAIL sb_entry pc=%02h op=%h rs=%h rt=%h imm=%h required pc=%02h instr=%02h",
                             dec_pc, dec_opcode, dec_rs, dec_rt, dec_imm, e, ins);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic start_run();
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        redirect_pc = 8'h00;
        repeat (2) @(posedge clk);
        sb.delete();
        mon_en = 1'b1;
        #1 rst_n = 1'b1;
    endtask

    task automatic push_range(input logic [7:0] first, input int n);
        logic [7:0] p;
        p = first;
        for (int i = 0; i < n; i++) begin
            sb.push_back(p);
            p = p + 8'd1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; mon_en = 1'b0;
        #3;
        @(negedge clk);
        checks++;
        if ({dec_valid, dec_pc, dec_opcode, dec_rs, dec_rt, dec_imm, halted, imem_rd_en, imem_addr} !== '0) begin
            errors++;
            $display("FAIL reset_state valid=%b pc=%02h op=%h halted=%b rd_en=%b addr=%02h required all zero",
                     dec_valid, dec_pc, dec_opcode, halted, imem_rd_en, imem_addr);
        end
    endtask

    task automatic test_straight();
        start_run();
        push_range(8'h00, 8);
        @(negedge clk);
        checks++;
        if (imem_rd_en !== 1'b1 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL first_issue rd_en=%b addr=%02h required 1/00", imem_rd_en, imem_addr);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early dec_valid=%b required 0", dec_valid);
        end
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (dec_valid !== 1'b1 || dec_pc !== 8'(i)) begin
                errors++;
                $display("FAIL stream valid=%b dec_pc=%02h required 1/%02h", dec_valid, dec_pc, i);
            end
            if (i == 3) begin
                checks++;
                if (dec_opcode !== 4'h1 || dec_imm !== 2'b11) begin
                    errors++;
                    $display("FAIL pc3_fields op=%h imm=%b required 1/11", dec_opcode, dec_imm);
                end
            end
            @(posedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL straight_drain left=%0d required 0", sb.size());
        end
        mon_en = 1'b0;
    endtask

    task automatic test_stall();
        start_run();
        push_range(8'h00, 8);
        repeat (4) @(posedge clk);
        #1 stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (dec_valid !== 1'b1 || dec_pc !== 8'h02 || imem_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold valid=%b dec_pc=%02h rd_en=%b required 1/02/0",
                         dec_valid, dec_pc, imem_rd_en);
            end
            @(posedge clk);
        end
        #1 stall = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_rd_en !== 1'b0 || dec_pc !== 8'h02) begin
            errors++;
            $display("FAIL skid_drain rd_en=%b dec_pc=%02h required 0/02", imem_rd_en, dec_pc);
        end
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL stall_drain left=%0d required 0", sb.size());
        end
        mon_en = 1'b0;
    endtask

    task automatic test_redirect();
        start_run();
        push_range(8'h00, 4);
        push_range(8'h40, 4);
        repeat (5) @(posedge clk);
        #1 redirect = 1'b1; redirect_pc = 8'h40;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (dec_valid !== 1'b0 || imem_addr !== 8'h40 || imem_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL redirect_issue valid=%b addr=%02h rd_en=%b required 0/40/1",
                     dec_valid, imem_addr, imem_rd_en);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_bubble dec_valid=%b required 0", dec_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 8'h40) begin
            errors++;
            $display("FAIL redirect_target valid=%b dec_pc=%02h required 1/40", dec_valid, dec_pc);
        end
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL redirect_drain left=%0d required 0", sb.size());
        end
        mon_en = 1'b0;
    endtask

    task automatic test_halt();
        mem[5] = 8'hF0;
        start_run();
        push_range(8'h00, 6);
        for (int i = 0; i < 30 && halted !== 1'b1; i++) @(negedge clk);
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_set halted=%b required 1", halted);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (imem_rd_en !== 1'b0 || halted !== 1'b1) begin
                errors++;
                $display("FAIL halt_hold rd_en=%b halted=%b required 0/1", imem_rd_en, halted);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL halt_presented left=%0d required 0", sb.size());
        end
        @(posedge clk);
        #1 redirect = 1'b1; redirect_pc = 8'h00;
        push_range(8'h00, 6);
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (halted !== 1'b0 || imem_rd_en !== 1'b1 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL halt_restart halted=%b rd_en=%b addr=%02h required 0/1/00",
                     halted, imem_rd_en, imem_addr);
        end
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL halt_restart_drain left=%0d required 0", sb.size());
        end
        repeat (4) @(posedge clk);
        mon_en = 1'b0;
        mem[5] = 8'h15;
    endtask

    task automatic test_wrap();
        start_run();
        redirect = 1'b1; redirect_pc = 8'hFE;
        push_range(8'hFE, 5);
        @(posedge clk);
        #1 redirect = 1'b0;
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL wrap_drain left=%0d required 0", sb.size());
        end
        mon_en = 1'b0;
    endtask

    task automatic test_async_reset();
        start_run();
        push_range(8'h00, 8);
        repeat (4) @(posedge clk);
        #1 stall = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dec_valid !== 1'b0 || halted !== 1'b0 || imem_rd_en !== 1'b0 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL async_reset valid=%b halted=%b rd_en=%b addr=%02h required 0/0/0/00",
                     dec_valid, halted, imem_rd_en, imem_addr);
        end
        mon_en = 1'b0;
        stall  = 1'b0;
        @(posedge clk);
        sb.delete();
        push_range(8'h00, 5);
        mon_en = 1'b1;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL async_restart_drain left=%0d required 0", sb.size());
        end
        mon_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {1'b0, 7'(i)};
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        mem[8'h40] = 8'h2D;
        mem[8'h41] = 8'h3A;
        mon_en = 1'b0;
        test_reset();
        test_straight();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
